alu_mdu: RTL

- Registered, parametrised successor of the single-cycle datapath ALU; adds an iterative multiply/divide unit with HI/LO result registers and a start/busy/done handshake.
- Sits in the EX stage of the multi-cycle core.
- Logic/arithmetic ops complete in one cycle. MULT/MULTU/DIV/DIVU take WIDTH+2 cycles; the controller stalls on busy.

---
 rtl/alu_mdu.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/alu_mdu.sv
// ============================================================================
// Module  : alu_mdu
// Brief   : Registered ALU with an iterative multiply/divide unit and HI/LO.
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module alu_mdu #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       alu_control,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done
);

    localparam logic [3:0] c_op_and  = 4'b0000;
    localparam logic [3:0] c_op_or   = 4'b0001;
    localparam logic [3:0] c_op_add  = 4'b0010;
    localparam logic [3:0] c_op_sltu = 4'b0011;
    localparam logic [3:0] c_op_sub  = 4'b0110;
    localparam logic [3:0] c_op_slt  = 4'b0111;
    localparam logic [3:0] c_op_nor  = 4'b1100;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t             r_state;
    logic               r_is_div;
    logic               r_neg_q;
    logic               r_neg_r;
    logic [WIDTH-1:0]   r_m;
    logic [WIDTH-1:0]   r_acc_hi;
    logic [WIDTH-1:0]   r_acc_lo;
    logic [CNT_W-1:0]   r_cnt;

    logic               w_accept;
    logic               w_is_md;
    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic [WIDTH-1:0]   w_alu_res;
    logic [WIDTH:0]     w_mul_sum;
    logic [WIDTH:0]     w_shift;
    logic               w_ge;
    logic [WIDTH-1:0]   w_sub;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_quo_fix;
    logic [WIDTH-1:0]   w_rem_fix;

    assign busy     = (r_state == S_ITER) || (r_state == S_FIX);
    assign done     = (r_state == S_DONE);
    assign zero     = (result == '0);
    assign w_accept = start && !busy;
    assign w_is_md  = (alu_control[3:2] == 2'b10);

    // bit0 selects the unsigned variant of MULT/DIV
    assign w_a_neg  = !alu_control[0] && a[WIDTH-1];
    assign w_b_neg  = !alu_control[0] && b[WIDTH-1];
    assign w_a_mag  = w_a_neg ? -a : a;
    assign w_b_mag  = w_b_neg ? -b : b;

    always_comb begin
        w_alu_res = '0;
        case (alu_control)
            c_op_and:  w_alu_res = a & b;
            c_op_or:   w_alu_res = a | b;
            c_op_add:  w_alu_res = a + b;
            c_op_sub:  w_alu_res = a - b;
            c_op_slt:  w_alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            c_op_sltu: w_alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
            c_op_nor:  w_alu_res = ~(a | b);
            default:   w_alu_res = '0;
        endcase
    end

    // Shift-add multiply: multiplier shifts out of acc_lo as product shifts in
    assign w_mul_sum  = {1'b0, r_acc_hi} + (r_acc_lo[0] ? {1'b0, r_m} : {(WIDTH+1){1'b0}});

    // Restoring divide: dividend shifts out of acc_lo as quotient bits shift in
    assign w_shift    = {r_acc_hi, r_acc_lo[WIDTH-1]};
    assign w_ge       = (w_shift >= {1'b0, r_m});
    assign w_sub      = w_shift[WIDTH-1:0] - r_m;

    assign w_prod_fix = r_neg_q ? -{r_acc_hi, r_acc_lo} : {r_acc_hi, r_acc_lo};
    assign w_quo_fix  = r_neg_q ? -r_acc_lo : r_acc_lo;
    assign w_rem_fix  = r_neg_r ? -r_acc_hi : r_acc_hi;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            result   <= '0;
            hi       <= '0;
            lo       <= '0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_m      <= '0;
            r_acc_hi <= '0;
            r_acc_lo <= '0;
            r_cnt    <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_accept) begin
                        if (w_is_md) begin
                            r_is_div <= alu_control[1];
                            r_m      <= alu_control[1] ? w_b_mag : w_a_mag;
                            r_acc_lo <= alu_control[1] ? w_a_mag : w_b_mag;
                            r_acc_hi <= '0;
                            // a zero divisor keeps the all-ones quotient unsigned
                            r_neg_q  <= (w_a_neg ^ w_b_neg) && !(alu_control[1] && (b == '0));
                            r_neg_r  <= w_a_neg;
                            r_cnt    <= '0;
                            r_state  <= S_ITER;
                        end else begin
                            result  <= w_alu_res;
                            r_state <= S_DONE;
                        end
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_ITER: begin
                    if (r_is_div) begin
                        r_acc_hi <= w_ge ? w_sub : w_shift[WIDTH-1:0];
                        r_acc_lo <= {r_acc_lo[WIDTH-2:0], w_ge};
                    end else begin
                        r_acc_hi <= w_mul_sum[WIDTH:1];
                        r_acc_lo <= {w_mul_sum[0], r_acc_lo[WIDTH-1:1]};
                    end
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_W'(WIDTH-1)) begin
                        r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    if (r_is_div) begin
                        hi     <= w_rem_fix;
                        lo     <= w_quo_fix;
                        result <= w_quo_fix;
                    end else begin
                        hi     <= w_prod_fix[2*WIDTH-1:WIDTH];
                        lo     <= w_prod_fix[WIDTH-1:0];
                        result <= w_prod_fix[WIDTH-1:0];
                    end
                    r_state <= S_DONE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire
